// File: rtl/add_arb_pkg.sv
// Shared definitions for the shared-adder arbiter: FSM encoding and default sizes.
package add_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEF_WORD_SIZE = 32;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_ID_W      = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/ADD_n_bit.sv
// Plain word_size-bit ripple-carry adder: Sum/Cout = A + B + Cin.
module ADD_n_bit #(
    parameter int word_size = 32
) (
    input  logic [word_size-1:0] A,
    input  logic [word_size-1:0] B,
    input  logic                 Cin,
    output logic [word_size-1:0] Sum,
    output logic                 Cout
);

    logic carry;

    // Carry ripples LSB to MSB through one full-adder cell per bit.
    always_comb begin
        Sum   = '0;
        carry = Cin;
        for (int i = 0; i < word_size; i++) begin
            Sum[i] = A[i] ^ B[i] ^ carry;
            carry  = (A[i] & B[i]) | (carry & (A[i] ^ B[i]));
        end
        Cout = carry;
    end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first valid requester after last_grant,
// wrapping modulo NUM_REQ. Returns one-hot grant, its index, and an any flag.
module rr_grant import add_arb_pkg::*; #(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ID_W    = DEF_ID_W
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_grant,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grant_id,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    // Walk the requesters starting just past the previous winner; first hit wins.
    always_comb begin
        grant     = '0;
        grant_id  = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!any_valid && req_valid[idx]) begin
                any_valid     = 1'b1;
                grant[idx]    = 1'b1;
                grant_id      = idx;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one ripple adder among NUM_REQ requesters, one operation at a time,
// granted round-robin. Result is returned on a single id-tagged response channel.
// Optional macro ADD_ARB_OVF_EN adds a registered signed-overflow output rsp_ovf.
module adder_share_arbiter import add_arb_pkg::*; #(
    parameter int word_size = DEF_WORD_SIZE,
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int ID_W      = DEF_ID_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*word_size-1:0] req_a,
    input  logic [NUM_REQ*word_size-1:0] req_b,
    input  logic [NUM_REQ-1:0]           req_cin,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [ID_W-1:0]              rsp_id,
    output logic [word_size-1:0]         rsp_sum,
    output logic                         rsp_cout
`ifdef ADD_ARB_OVF_EN
    ,
    output logic                         rsp_ovf
`endif
);

    state_t state, state_nxt;

    logic [NUM_REQ-1:0][word_size-1:0] a_v, b_v;
    logic [NUM_REQ-1:0]                grant;
    logic [ID_W-1:0]                   grant_id;
    logic                              any_valid;
    logic [ID_W-1:0]                   last_grant;

    logic [word_size-1:0]              op_a, op_b;
    logic                              op_cin;
    logic [ID_W-1:0]                   op_id;
    logic [word_size-1:0]              add_sum;
    logic                              add_cout;

    assign a_v = req_a;
    assign b_v = req_b;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .req_valid  (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .grant_id   (grant_id),
        .any_valid  (any_valid)
    );

    // Adder only ever sees the latched operands, so late input changes are harmless.
    ADD_n_bit #(
        .word_size (word_size)
    ) u_add (
        .A    (op_a),
        .B    (op_b),
        .Cin  (op_cin),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: accept -> compute -> hold result until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_valid) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs: ready only to the winner while idle (and never during reset).
    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE:    if (!rst) req_ready = grant;
            RESP:    rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Operand capture and round-robin pointer update on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a       <= '0;
            op_b       <= '0;
            op_cin     <= 1'b0;
            op_id      <= '0;
            last_grant <= ID_W'(NUM_REQ - 1);
        end else if (state == IDLE && any_valid) begin
            op_a       <= a_v[grant_id];
            op_b       <= b_v[grant_id];
            op_cin     <= req_cin[grant_id];
            op_id      <= grant_id;
            last_grant <= grant_id;
        end
    end

    // Result registers load once in CALC and then hold through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_id   <= '0;
            rsp_sum  <= '0;
            rsp_cout <= 1'b0;
`ifdef ADD_ARB_OVF_EN
            rsp_ovf  <= 1'b0;
`endif
        end else if (state == CALC) begin
            rsp_id   <= op_id;
            rsp_sum  <= add_sum;
            rsp_cout <= add_cout;
`ifdef ADD_ARB_OVF_EN
            // Signed overflow: like-signed operands producing an opposite-signed sum.
            rsp_ovf  <= (op_a[word_size-1] == op_b[word_size-1]) &&
                        (add_sum[word_size-1] != op_a[word_size-1]);
`endif
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed corner cases plus
// randomized traffic against an arithmetic/round-robin reference model.
module tb_adder_share_arbiter;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int IW = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0]         req_ready;
    logic [NR-1:0][W-1:0]  opa, opb;
    logic [NR-1:0]         opc;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IW-1:0]         rsp_id;
    logic [W-1:0]          rsp_sum;
    logic                  rsp_cout;
`ifdef ADD_ARB_OVF_EN
    logic                  rsp_ovf;
`endif

    int n_pass = 0;
    int n_fail = 0;
    int cyc    = 0;
    int ptr;       // model of last granted requester
    int acc_cyc;   // cycle stamp of the most recent acceptance
    int prev_acc;

    adder_share_arbiter #(.word_size(W), .NUM_REQ(NR), .ID_W(IW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (opa),
        .req_b     (opb),
        .req_cin   (opc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADD_ARB_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Round-robin rule: first requester after p, wrapping.
    function automatic int pick(input logic [NR-1:0] m, input int p);
        for (int k = 1; k <= NR; k++)
            if (m[(p + k) % NR]) return (p + k) % NR;
        return -1;
    endfunction

    task automatic scramble();
        for (int i = 0; i < NR; i++) begin
            opa[i] = $urandom;
            opb[i] = $urandom;
            opc[i] = 1'($urandom);
        end
    endtask

    task automatic idle_cycles(input int n);
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            #1;
            check("idle_ready", 64'(req_ready), 64'(0));
            check("idle_valid", 64'(rsp_valid), 64'(0));
            @(negedge clk);
        end
    endtask

    // One full transaction, entered and left on an IDLE-state negedge.
    task automatic op(input logic [NR-1:0] mask, input int hold, input bit noisy);
        int          g;
        logic [W:0]  full;
        logic [W-1:0] ea, eb;
        logic        ec;
`ifdef ADD_ARB_OVF_EN
        logic        eo;
`endif
        req_valid = mask;
        #1;
        check("pre_rsp_valid", 64'(rsp_valid), 64'(0));
        g = pick(mask, ptr);
        check("req_ready", 64'(req_ready), 64'(1) << g);
        ea   = opa[g];
        eb   = opb[g];
        ec   = opc[g];
        full = {1'b0, ea} + {1'b0, eb} + {{W{1'b0}}, ec};
`ifdef ADD_ARB_OVF_EN
        eo   = (ea[W-1] == eb[W-1]) && (full[W-1] != ea[W-1]);
`endif
        ptr      = g;
        prev_acc = acc_cyc;
        acc_cyc  = cyc;
        rsp_ready = (hold == 0);

        @(negedge clk);
        if (noisy) req_valid = NR'($urandom);
        scramble();
        #1;
        check("calc_ready", 64'(req_ready), 64'(0));
        check("calc_valid", 64'(rsp_valid), 64'(0));

        @(negedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("rsp_sum", 64'(rsp_sum), 64'(full[W-1:0]));
        check("rsp_cout", 64'(rsp_cout), 64'(full[W]));
        check("resp_ready", 64'(req_ready), 64'(0));
`ifdef ADD_ARB_OVF_EN
        check("rsp_ovf", 64'(rsp_ovf), 64'(eo));
`endif
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (noisy) req_valid = NR'($urandom);
            #1;
            check("hold_valid", 64'(rsp_valid), 64'(1));
            check("hold_sum", 64'(rsp_sum), 64'(full[W-1:0]));
            check("hold_id", 64'(rsp_id), 64'(g));
            check("hold_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        req_valid = '0;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        opa       = '0;
        opb       = '0;
        opc       = '0;
        ptr       = NR - 1;
        acc_cyc   = 0;
        prev_acc  = 0;

        // Reset state, with requests pending to prove ready stays low.
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 64'(req_ready), 64'(0));
        check("rst_valid", 64'(rsp_valid), 64'(0));
        check("rst_id", 64'(rsp_id), 64'(0));
        check("rst_sum", 64'(rsp_sum), 64'(0));
        check("rst_cout", 64'(rsp_cout), 64'(0));
`ifdef ADD_ARB_OVF_EN
        check("rst_ovf", 64'(rsp_ovf), 64'(0));
`endif
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);

        // 5 + 7 + 0 from requester 0.
        opa[0] = 32'd5; opb[0] = 32'd7; opc[0] = 1'b0;
        op(4'b0001, 0, 1'b0);

        // Wrap: FFFFFFFF + 0 + 1.
        opa[1] = 32'hFFFF_FFFF; opb[1] = 32'h0; opc[1] = 1'b1;
        op(4'b0010, 0, 1'b0);

        // Signed-overflow corners.
        opa[2] = 32'h7FFF_FFFF; opb[2] = 32'h1; opc[2] = 1'b0;
        op(4'b0100, 0, 1'b0);
        opa[3] = 32'h8000_0000; opb[3] = 32'h8000_0000; opc[3] = 1'b0;
        op(4'b1000, 0, 1'b0);

        // All requesting, consumer always ready: 0,1,2,3,0 at one op per 3 cycles.
        for (int n = 0; n < 5; n++) begin
            op(4'b1111, 0, 1'b0);
            if (n > 0) check("throughput", 64'(acc_cyc - prev_acc), 64'(3));
        end

        // Back-pressure for 5 cycles with request noise while busy.
        op(4'b0110, 5, 1'b1);

        // Consumer ready while idle must not create a response.
        idle_cycles(3);

        // Reset while the grant-2 operation is in CALC.
        req_valid = 4'b0100;
        #1;
        check("pre_rst_grant", 64'(req_ready), 64'(1) << pick(4'b0100, ptr));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_ready", 64'(req_ready), 64'(0));
        check("midrst_valid", 64'(rsp_valid), 64'(0));
        check("midrst_id", 64'(rsp_id), 64'(0));
        check("midrst_sum", 64'(rsp_sum), 64'(0));
        check("midrst_cout", 64'(rsp_cout), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        ptr = NR - 1;
        idle_cycles(3);
        op(4'b1001, 0, 1'b0);

        // Randomized traffic.
        for (int n = 0; n < 25; n++) begin
            op(NR'($urandom_range(1, 15)), int'($urandom_range(0, 2)), 1'b1);
        end
        idle_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
        $finish;
    end

endmodule
